// File: rtl/axis_packet_gen.sv
`default_nettype none
// ============================================================================
// Module   : axis_packet_gen
// Purpose  : AXI4-Stream traffic source. Emits a run of packets with
//            programmable length, count, inter-packet gap, partial final
//            beat and data pattern. All outputs are registered.
// Revision : 1.0 - initial release
// ============================================================================
module axis_packet_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int GAP_WIDTH  = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                             ACLK,
  input  logic                             ARESET,
  input  logic                             start,
  input  logic                             stop,
  input  logic [LEN_WIDTH-1:0]             cfg_len,
  input  logic [CNT_WIDTH-1:0]             cfg_num_pkts,
  input  logic [GAP_WIDTH-1:0]             cfg_gap,
  input  logic [$clog2(DATA_WIDTH/8):0]    cfg_tail_bytes,
  input  logic [1:0]                       cfg_mode,
  input  logic [DATA_WIDTH-1:0]            cfg_seed,
  output logic                             busy,
  output logic                             done,
  output logic [CNT_WIDTH-1:0]             pkt_count,
  output logic [DATA_WIDTH-1:0]            M_AXIS_TDATA,
  output logic [DATA_WIDTH/8-1:0]          M_AXIS_TKEEP,
  output logic                             M_AXIS_TVALID,
  input  logic                             M_AXIS_TREADY,
  output logic                             M_AXIS_TLAST
);

  localparam int KEEP_WIDTH = DATA_WIDTH / 8;
  localparam int TAIL_WIDTH = $clog2(KEEP_WIDTH) + 1;
  localparam int HALF_WIDTH = DATA_WIDTH / 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

  state_t                  state, state_nx;

  // Shadow copies of the configuration, frozen for the duration of a run
  logic [LEN_WIDTH-1:0]    len_sh;
  logic [CNT_WIDTH-1:0]    num_sh;
  logic [GAP_WIDTH-1:0]    gap_sh;
  logic [TAIL_WIDTH-1:0]   tail_sh;
  logic [1:0]              mode_sh;
  logic [DATA_WIDTH-1:0]   seed_sh;

  logic [LEN_WIDTH-1:0]    beat, beat_nx;
  logic [GAP_WIDTH-1:0]    gap_cnt, gap_nx;
  logic [CNT_WIDTH-1:0]    pkt_nx, pkt_inc;
  logic                    stop_pend, pend_nx;
  logic                    valid_nx, done_nx, load;
  logic                    fire, last_beat, stop_req, run_end;

  // Pattern sources: the live cfg inputs on the loading cycle, shadows after
  logic [LEN_WIDTH-1:0]    src_len;
  logic [TAIL_WIDTH-1:0]   src_tail;
  logic [1:0]              src_mode;
  logic [DATA_WIDTH-1:0]   src_seed;
  logic [DATA_WIDTH-1:0]   raw_nx, data_nx;
  logic [KEEP_WIDTH-1:0]   keep_nx;
  logic                    last_nx;

  function automatic logic [DATA_WIDTH-1:0] pattern(
    input logic [1:0]            mode,
    input logic [DATA_WIDTH-1:0] seed,
    input logic [CNT_WIDTH-1:0]  p,
    input logic [LEN_WIDTH-1:0]  b
  );
    logic [LEN_WIDTH-1:0] bit_pos;
    bit_pos = b % LEN_WIDTH'(DATA_WIDTH);
    case (mode)
      2'd0:    return seed + DATA_WIDTH'(b);
      2'd1:    return seed;
      2'd2:    return {HALF_WIDTH'(p), HALF_WIDTH'(b)};
      default: return DATA_WIDTH'(1) << bit_pos;
    endcase
  endfunction

  assign fire      = M_AXIS_TVALID & M_AXIS_TREADY;
  assign last_beat = (beat == len_sh - LEN_WIDTH'(1));
  assign stop_req  = stop_pend | stop;
  assign pkt_inc   = (&pkt_count) ? pkt_count : pkt_count + CNT_WIDTH'(1);
  assign run_end   = (num_sh != '0) && (pkt_count + CNT_WIDTH'(1) == num_sh);

  // Next state, beat/packet/gap counters and stop bookkeeping
  always_comb begin
    state_nx = state;
    beat_nx  = beat;
    pkt_nx   = pkt_count;
    gap_nx   = gap_cnt;
    pend_nx  = stop_pend;
    valid_nx = 1'b0;
    done_nx  = 1'b0;
    load     = 1'b0;
    case (state)
      ST_IDLE: begin
        pend_nx = 1'b0;
        if (start && (cfg_len != '0)) begin
          load     = 1'b1;
          state_nx = ST_STREAM;
          beat_nx  = '0;
          pkt_nx   = '0;
          valid_nx = 1'b1;
        end
      end
      ST_STREAM: begin
        valid_nx = 1'b1;
        pend_nx  = stop_req;
        if (fire) begin
          if (last_beat) begin
            pkt_nx  = pkt_inc;
            beat_nx = '0;
            if (run_end || stop_req) begin
              state_nx = ST_IDLE;
              valid_nx = 1'b0;
              done_nx  = 1'b1;
              pend_nx  = 1'b0;
            end else if (gap_sh != '0) begin
              state_nx = ST_GAP;
              gap_nx   = gap_sh;
              valid_nx = 1'b0;
            end
          end else begin
            beat_nx = beat + LEN_WIDTH'(1);
          end
        end
      end
      ST_GAP: begin
        pend_nx = stop_req;
        if (stop_req) begin
          state_nx = ST_IDLE;
          done_nx  = 1'b1;
          pend_nx  = 1'b0;
        end else if (gap_cnt <= GAP_WIDTH'(1)) begin
          state_nx = ST_STREAM;
          valid_nx = 1'b1;
        end else begin
          gap_nx = gap_cnt - GAP_WIDTH'(1);
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Contents of the beat to be presented after the next edge
  always_comb begin
    src_len  = load ? cfg_len        : len_sh;
    src_tail = load ? cfg_tail_bytes : tail_sh;
    src_mode = load ? cfg_mode       : mode_sh;
    src_seed = load ? cfg_seed       : seed_sh;
    raw_nx   = pattern(src_mode, src_seed, pkt_nx, beat_nx);
    last_nx  = valid_nx && (beat_nx == src_len - LEN_WIDTH'(1));
    if (!valid_nx)
      keep_nx = '0;
    else if (last_nx && (src_tail != '0))
      keep_nx = ~({KEEP_WIDTH{1'b1}} << src_tail);
    else
      keep_nx = '1;
    data_nx = '0;
    for (int i = 0; i < KEEP_WIDTH; i++)
      data_nx[8*i +: 8] = keep_nx[i] ? raw_nx[8*i +: 8] : 8'h00;
  end

  // State, counters, shadow configuration and registered outputs
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state         <= ST_IDLE;
      beat          <= '0;
      gap_cnt       <= '0;
      stop_pend     <= 1'b0;
      len_sh        <= '0;
      num_sh        <= '0;
      gap_sh        <= '0;
      tail_sh       <= '0;
      mode_sh       <= '0;
      seed_sh       <= '0;
      pkt_count     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TDATA  <= '0;
      M_AXIS_TKEEP  <= '0;
      M_AXIS_TLAST  <= 1'b0;
    end else begin
      state         <= state_nx;
      beat          <= beat_nx;
      gap_cnt       <= gap_nx;
      stop_pend     <= pend_nx;
      pkt_count     <= pkt_nx;
      busy          <= (state_nx != ST_IDLE);
      done          <= done_nx;
      M_AXIS_TVALID <= valid_nx;
      M_AXIS_TDATA  <= data_nx;
      M_AXIS_TKEEP  <= keep_nx;
      M_AXIS_TLAST  <= last_nx;
      if (load) begin
        len_sh  <= cfg_len;
        num_sh  <= cfg_num_pkts;
        gap_sh  <= cfg_gap;
        tail_sh <= cfg_tail_bytes;
        mode_sh <= cfg_mode;
        seed_sh <= cfg_seed;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axis_packet_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_packet_gen
// Purpose  : Self-checking bench for axis_packet_gen: configuration table,
//            randomized runs against a packet-level reference model, and
//            hand-written stop/reset/illegal-length sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_packet_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, stop = 1'b0;
  logic [15:0] cfg_len = '0;
  logic [15:0] cfg_num_pkts = '0;
  logic [7:0]  cfg_gap = '0;
  logic [2:0]  cfg_tail_bytes = '0;
  logic [1:0]  cfg_mode = '0;
  logic [31:0] cfg_seed = '0;
  logic        busy, done;
  logic [15:0] pkt_count;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tvalid, tlast;
  logic        tready = 1'b0;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  typedef struct {
    int          len, num, gap, tail, mode;
    logic [31:0] seed;
    int          rdy, stop_pkt, stop_beat, exp_pkts;
  } vec_t;

  always #5 clk = ~clk;

  axis_packet_gen #(
    .DATA_WIDTH(32), .LEN_WIDTH(16), .GAP_WIDTH(8), .CNT_WIDTH(16)
  ) dut (
    .ACLK(clk), .ARESET(rst), .start(start), .stop(stop),
    .cfg_len(cfg_len), .cfg_num_pkts(cfg_num_pkts), .cfg_gap(cfg_gap),
    .cfg_tail_bytes(cfg_tail_bytes), .cfg_mode(cfg_mode), .cfg_seed(cfg_seed),
    .busy(busy), .done(done), .pkt_count(pkt_count),
    .M_AXIS_TDATA(tdata), .M_AXIS_TKEEP(tkeep), .M_AXIS_TVALID(tvalid),
    .M_AXIS_TREADY(tready), .M_AXIS_TLAST(tlast)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference beat straight from the pattern/keep/last rules
  function automatic beat_t model_beat(int len, int tail, int mode, logic [31:0] seed, int p, int b);
    beat_t       r;
    logic [31:0] raw, mask;
    case (mode)
      0:       raw = seed + b;
      1:       raw = seed;
      2:       raw = {p[15:0], b[15:0]};
      default: raw = 32'd1 << (b % 32);
    endcase
    r.last = (b == len - 1);
    r.keep = (r.last && tail != 0) ? 4'((1 << tail) - 1) : 4'hF;
    for (int i = 0; i < 4; i++) mask[8*i +: 8] = r.keep[i] ? 8'hFF : 8'h00;
    r.data = raw & mask;
    return r;
  endfunction

  // Start one run from a negedge and follow it to the done pulse
  task automatic run_test(input vec_t v);
    beat_t exp_q[$];
    beat_t prev;
    int    npk, idx, low, cyc;
    logic  prev_stall, fired_prev, stop_sent;
    npk = (v.num == 0) ? v.stop_pkt + 1 : v.num;
    for (int p = 0; p < npk; p++)
      for (int b = 0; b < v.len; b++)
        exp_q.push_back(model_beat(v.len, v.tail, v.mode, v.seed, p, b));
    cfg_len        = 16'(v.len);
    cfg_num_pkts   = 16'(v.num);
    cfg_gap        = 8'(v.gap);
    cfg_tail_bytes = 3'(v.tail);
    cfg_mode       = 2'(v.mode);
    cfg_seed       = v.seed;
    stop  = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy_valid", {busy, tvalid}, 2'b11);
    idx = 0; low = 0; cyc = 0;
    prev_stall = 1'b0; fired_prev = 1'b0; stop_sent = 1'b0;
    prev = '{default: '0};
    while (!done) begin
      if (cyc++ > 4000) begin
        checks++; failures++;
        $display("FAIL run_timeout actual=no_done required=done len=%0d num=%0d", v.len, v.num);
        break;
      end
      if (prev_stall)
        check("stall_stable", {tdata, tkeep, tlast}, {prev.data, prev.keep, prev.last});
      // scramble cfg and poke start while busy: both must be ignored
      cfg_len        = 16'($urandom);
      cfg_num_pkts   = 16'($urandom);
      cfg_gap        = 8'($urandom);
      cfg_tail_bytes = 3'($urandom);
      cfg_mode       = 2'($urandom);
      cfg_seed       = $urandom;
      start          = 1'($urandom_range(0, 1));
      stop           = 1'b0;
      tready         = ($urandom_range(1, 100) <= v.rdy);
      if (tvalid) begin
        if (idx >= exp_q.size()) begin
          checks++; failures++;
          $display("FAIL extra_beat actual=beat%0d required=%0d_beats", idx, exp_q.size());
        end else begin
          if (!prev_stall && idx != 0 && (idx % v.len) == 0)
            check("gap_cycles", 64'(low), 64'(v.gap));
          if ((idx % v.len) == 0) low = 0;
          check("beat", {tdata, tkeep, tlast}, {exp_q[idx].data, exp_q[idx].keep, exp_q[idx].last});
        end
        if (v.stop_pkt >= 0 && !stop_sent && idx == v.stop_pkt * v.len + v.stop_beat) begin
          stop = 1'b1;
          stop_sent = 1'b1;
        end
        prev.data = tdata; prev.keep = tkeep; prev.last = tlast;
        prev_stall = !tready;
        fired_prev = tready;
        if (tready) idx++;
      end else begin
        low++;
        prev_stall = 1'b0;
        fired_prev = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    stop  = 1'b0;
    check("done_state", {done, busy, tvalid}, 3'b100);
    check("done_after_last_fire", 64'(fired_prev), 64'd1);
    check("beat_total", 64'(idx), 64'(exp_q.size()));
    check("pkt_count", 64'(pkt_count), 64'(v.exp_pkts));
    @(negedge clk);
    check("done_pulse_width", 64'(done), 64'd0);
  endtask

  vec_t tbl[8];
  vec_t rv;
  int   vcount, dcount;

  initial begin
    //           len num gap tail mode seed          rdy stop_pkt stop_beat exp_pkts
    tbl[0] = '{  4,  1,  0,  0,  0, 32'h0000_0010, 100, -1, 0, 1};
    tbl[1] = '{  5,  3,  0,  0,  2, 32'h0000_DEAD,  50, -1, 0, 3};
    tbl[2] = '{  2,  2,  3,  1,  0, 32'hAABB_CCDD, 100, -1, 0, 2};
    tbl[3] = '{  8,  0,  0,  0,  0, 32'h0000_0100, 100,  1, 2, 2};
    tbl[4] = '{  1,  6,  0,  0,  3, 32'h0000_0000,  70, -1, 0, 6};
    tbl[5] = '{  3,  4,  2,  3,  1, 32'h1234_5678,  60, -1, 0, 4};
    tbl[6] = '{ 40,  2,  1,  4,  3, 32'h0000_0000,  80, -1, 0, 2};
    tbl[7] = '{  8,  0,  2,  2,  2, 32'hFFFF_FFFF,  75,  2, 7, 3};

    repeat (2) @(negedge clk);
    check("reset_outputs", {tvalid, tlast, busy, done, tdata, tkeep, pkt_count}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_test(tbl[i]);

    for (int i = 0; i < 6; i++) begin
      rv.len  = $urandom_range(1, 6);
      rv.num  = $urandom_range(1, 4);
      rv.gap  = $urandom_range(0, 3);
      rv.tail = $urandom_range(0, 4);
      rv.mode = $urandom_range(0, 3);
      rv.seed = $urandom;
      rv.rdy  = $urandom_range(30, 100);
      rv.stop_pkt = -1; rv.stop_beat = 0;
      rv.exp_pkts = rv.num;
      run_test(rv);
    end

    // stop while in GAP: no further beats, single done, one packet counted
    cfg_len = 16'd2; cfg_num_pkts = 16'd0; cfg_gap = 8'd10; cfg_tail_bytes = 3'd0;
    cfg_mode = 2'd0; cfg_seed = 32'd0; tready = 1'b1;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("gap_entered_valid", 64'(tvalid), 64'd0);
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    vcount = 0; dcount = 0;
    for (int i = 0; i < 20; i++) begin
      if (tvalid) vcount++;
      if (done) dcount++;
      @(negedge clk);
    end
    check("stop_gap_beats", 64'(vcount), 64'd0);
    check("stop_gap_done", 64'(dcount), 64'd1);
    check("stop_gap_state", {busy, pkt_count}, {1'b0, 16'd1});

    // asynchronous reset in the middle of packet 1
    cfg_len = 16'd8; cfg_num_pkts = 16'd0; cfg_gap = 8'd0; tready = 1'b1;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_reset_pkt_count", {tvalid, pkt_count, tdata}, {1'b1, 16'd1, 32'd1});
    #2 rst = 1'b1;
    #1 check("async_reset_outputs", {tvalid, tlast, busy, done, tdata, tkeep, pkt_count}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tready = 1'b0;
    @(negedge clk);
    rv = '{3, 1, 0, 0, 0, 32'h0000_0040, 100, -1, 0, 1};
    run_test(rv);

    // a start with len=0 is ignored
    cfg_len = 16'd0; cfg_num_pkts = 16'd1;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("len0_ignored", {busy, tvalid}, 2'b00);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
